// File: rtl/nixie_pkg.sv
// Shared constants for the seven-segment read-back path: active-low glyphs,
// frame geometry and the capture FSM state type.
package nixie_pkg;
  localparam int DIGITS  = 4;
  localparam int FIELD_W = 5;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic {IDLE, COLLECT} state_e;
endpackage

// File: rtl/nixie_seg_decode.sv
// Active-low segment pattern to hex nibble; ok_o low for any non-glyph pattern.
module nixie_seg_decode
  import nixie_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       ok_o,
  output logic [3:0] nib_o
);
  always_comb begin
    ok_o  = 1'b1;
    nib_o = 4'h0;
    case (seg_i)
      SEG_0:   nib_o = 4'h0;
      SEG_1:   nib_o = 4'h1;
      SEG_2:   nib_o = 4'h2;
      SEG_3:   nib_o = 4'h3;
      SEG_4:   nib_o = 4'h4;
      SEG_5:   nib_o = 4'h5;
      SEG_6:   nib_o = 4'h6;
      SEG_7:   nib_o = 4'h7;
      SEG_8:   nib_o = 4'h8;
      SEG_9:   nib_o = 4'h9;
      SEG_A:   nib_o = 4'hA;
      SEG_B:   nib_o = 4'hB;
      SEG_C:   nib_o = 4'hC;
      SEG_D:   nib_o = 4'hD;
      SEG_E:   nib_o = 4'hE;
      SEG_F:   nib_o = 4'hF;
      default: ok_o  = 1'b0;
    endcase
  end
endmodule

// File: rtl/nixie_capture.sv
// Samples a scanned 4-digit seven-segment display and rebuilds its DATA word.
// Define NIXIE_CAPTURE_CHANGE_ONLY_EN to suppress valid for repeated frames.
module nixie_capture
  import nixie_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int FRAME_TIMEOUT = 1048576,
  parameter int TMR_W         = 21
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        en,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        dp,
  output logic [31:0] DATA_OUT,
  output logic        valid,
  output logic        frame_err,
  output logic        busy
);
  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;

  logic [11:0] sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q;
  state_e state_q;
  logic [DIGITS-1:0] seen_q, bad_q;
  logic [DIGITS-1:0][FIELD_W-1:0] slot_q;
  logic [31:0] data_q, frame_d;
  logic valid_q, err_q;
  logic changed, sel_ok, cap, done, tout, dec_ok, pulse_ok;
  logic [1:0] sel_k;
  logic [3:0] dec_nib;
`ifdef NIXIE_CAPTURE_CHANGE_ONLY_EN
  logic shown_q;
`endif

  // synchronized fields: {seg[6:0], an[3:0], dp}
  nixie_seg_decode u_dec (.seg_i(sync2_q[11:5]), .ok_o(dec_ok), .nib_o(dec_nib));

  always_comb begin
    sel_ok = 1'b1;
    sel_k  = 2'd0;
    case (sync2_q[4:1])
      4'b1110: sel_k = 2'd0;
      4'b1101: sel_k = 2'd1;
      4'b1011: sel_k = 2'd2;
      4'b0111: sel_k = 2'd3;
      default: sel_ok = 1'b0;
    endcase
  end

  assign changed = (sync2_q != prev_q);
  assign cnt_d   = changed ? '0 :
                   (cnt_q == CNT_W'(STABLE_CYCLES-1)) ? cnt_q : cnt_q + 1'b1;
  // fires on the edge where the counter steps into STABLE_CYCLES-1, once per dwell
  assign cap     = (state_q == COLLECT) && en && sel_ok && !changed &&
                   (cnt_q == CNT_W'(STABLE_CYCLES-2));
  assign done    = (seen_q == '1);
  assign tout    = (seen_q != '0) && (tmr_q == TMR_W'(FRAME_TIMEOUT-1));
  assign frame_d = {12'h0, slot_q};

`ifdef NIXIE_CAPTURE_CHANGE_ONLY_EN
  assign pulse_ok = !shown_q || (frame_d != data_q);
`else
  assign pulse_ok = 1'b1;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      state_q <= IDLE;
      seen_q  <= '0;
      bad_q   <= '0;
      slot_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef NIXIE_CAPTURE_CHANGE_ONLY_EN
      shown_q <= 1'b0;
`endif
    end else begin
      sync1_q <= {seg, an, dp};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: if (en) state_q <= COLLECT;
        COLLECT: begin
          if (!en) begin
            state_q <= IDLE;
            seen_q  <= '0;
            bad_q   <= '0;
            tmr_q   <= '0;
          end else begin
            if (done) begin
              if (bad_q == '0) begin
                data_q  <= frame_d;
                valid_q <= pulse_ok;
`ifdef NIXIE_CAPTURE_CHANGE_ONLY_EN
                shown_q <= 1'b1;
`endif
              end else begin
                err_q <= 1'b1;
              end
              seen_q <= '0;
              bad_q  <= '0;
              tmr_q  <= '0;
            end else if (tout) begin
              err_q  <= 1'b1;
              seen_q <= '0;
              bad_q  <= '0;
              tmr_q  <= '0;
            end else if (seen_q != '0) begin
              tmr_q <= tmr_q + 1'b1;
            end
            // a capture on a clearing edge starts the next frame
            if (cap) begin
              seen_q[sel_k] <= 1'b1;
              bad_q[sel_k]  <= !dec_ok;
              slot_q[sel_k] <= {~sync2_q[0], dec_nib};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DATA_OUT  = data_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (seen_q != '0);
endmodule

// File: tb/tb_nixie_capture.sv
// Scoreboard bench for nixie_capture: stimulus queues expected pulses, a
// negedge monitor pops and compares every valid/frame_err pulse.
module tb_nixie_capture;
  import nixie_pkg::*;

  localparam int STABLE = 16;
  localparam int FT     = 256;

  logic        HCLK = 1'b0;
  logic        HRESET, en, dp;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [31:0] DATA_OUT;
  logic        valid, frame_err, busy;

  always #5 HCLK = ~HCLK;

  nixie_capture #(.STABLE_CYCLES(STABLE), .FRAME_TIMEOUT(FT), .TMR_W(9)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .en(en), .seg(seg), .an(an), .dp(dp),
    .DATA_OUT(DATA_OUT), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  typedef struct packed {logic err; logic [31:0] data;} exp_t;
  exp_t expq[$];

  int checks = 0, errors = 0;
  int cyc = 0, last_valid_cyc = -1, last_err_cyc = -1, t_last = 0, busy_cyc;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_pulse(input logic err, input logic [31:0] d);
    exp_t e;
    e.err  = err;
    e.data = d;
    expq.push_back(e);
  endtask

  // monitor
  always @(negedge HCLK) begin
    exp_t e;
    if (HRESET === 1'b0 && (valid === 1'b1 || frame_err === 1'b1)) begin
      if (valid === 1'b1) last_valid_cyc = cyc;
      if (frame_err === 1'b1) last_err_cyc = cyc;
      if (expq.size() == 0) begin
        chk("unexpected_pulse", {30'h0, valid, frame_err}, 32'h0);
      end else begin
        e = expq.pop_front();
        chk("pulse_kind", {30'h0, valid, frame_err}, {30'h0, !e.err, e.err});
        chk("pulse_data", DATA_OUT, e.data);
      end
    end
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an  = a;
    seg = s;
    dp  = d;
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // dots is active-high per digit; ndig limits how many digits are shown
  task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                      input logic [6:0] s3, input logic [3:0] dots, input bit ghost,
                      input int ndig);
    logic [6:0] ss [4];
    logic [3:0] a;
    ss = '{s0, s1, s2, s3};
    for (int k = 0; k < ndig; k++) begin
      a    = 4'hF;
      a[k] = 1'b0;
      if (k == 3) t_last = cyc;
      hold(a, ss[k], ~dots[k], 64);
      if (ghost && k < 3) hold(a, SEG_8, 1'b1, 5);
    end
  endtask

  initial begin
    repeat (20000) @(posedge HCLK);
    $display("FAIL watchdog cycles %0d limit %0d", cyc, 20000);
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESET = 1'b1; en = 1'b0; an = 4'hF; seg = 7'h7F; dp = 1'b1;
    @(posedge HCLK); #1;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_data", DATA_OUT, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_err", {31'h0, frame_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    HRESET = 1'b0; en = 1'b1;
    hold(4'hF, 7'h7F, 1'b1, 10);

    // reference frame
    expect_pulse(1'b0, 32'h00020E41);
    scan(SEG_1, SEG_2, SEG_3, SEG_4, 4'b0010, 1'b0, 4);
    chk("ref_latency", last_valid_cyc - t_last, STABLE + 3);
    chk("ref_data", DATA_OUT, 32'h00020E41);
    chk("ref_busy", {31'h0, busy}, 32'h0);
    hold(4'hF, 7'h7F, 1'b1, 20);

    // ghost glitches, same frame again
`ifndef NIXIE_CAPTURE_CHANGE_ONLY_EN
    expect_pulse(1'b0, 32'h00020E41);
`endif
    scan(SEG_1, SEG_2, SEG_3, SEG_4, 4'b0010, 1'b1, 4);
    chk("ghost_data", DATA_OUT, 32'h00020E41);
    hold(4'hF, 7'h7F, 1'b1, 20);

    // new digit0 = F
    expect_pulse(1'b0, 32'h00020E4F);
    scan(SEG_F, SEG_2, SEG_3, SEG_4, 4'b0010, 1'b0, 4);
    chk("f_data", DATA_OUT, 32'h00020E4F);
    hold(4'hF, 7'h7F, 1'b1, 20);

    // undecodable digit 2
    expect_pulse(1'b1, 32'h00020E4F);
    scan(SEG_1, SEG_2, 7'h7F, SEG_4, 4'b0010, 1'b0, 4);
    chk("bad_data", DATA_OUT, 32'h00020E4F);
    chk("bad_busy", {31'h0, busy}, 32'h0);
    hold(4'hF, 7'h7F, 1'b1, 20);

    // timeout with a single digit
    expect_pulse(1'b1, 32'h00020E4F);
    an = 4'b1110; seg = SEG_5; dp = 1'b1;
    busy_cyc = -1;
    for (int i = 0; i < 60 && busy_cyc < 0; i++) begin
      @(negedge HCLK);
      if (busy === 1'b1) busy_cyc = cyc;
    end
    chk("tout_busy_rise", {31'h0, busy_cyc >= 0}, 32'h1);
    repeat (300) @(posedge HCLK);
    #1;
    chk("tout_cycles", last_err_cyc - busy_cyc, FT);
    chk("tout_busy", {31'h0, busy}, 32'h0);
    hold(4'hF, 7'h7F, 1'b1, 20);

    // reset mid-frame
    scan(SEG_1, SEG_2, SEG_3, SEG_4, 4'b0010, 1'b0, 3);
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    HRESET = 1'b1;
    hold(4'hF, 7'h7F, 1'b1, 3);
    HRESET = 1'b0;
    hold(4'hF, 7'h7F, 1'b1, 40);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_data", DATA_OUT, 32'h0);

    // enable dropped mid-frame
    scan(SEG_1, SEG_2, SEG_3, SEG_4, 4'b0010, 1'b0, 3);
    chk("pre_en_busy", {31'h0, busy}, 32'h1);
    en = 1'b0;
    hold(4'b1011, SEG_3, 1'b1, 3);
    chk("en_drop_busy", {31'h0, busy}, 32'h0);
    hold(4'b0111, SEG_4, 1'b1, 64);
    chk("en_off_nocap", {31'h0, busy}, 32'h0);
    en = 1'b1;
    hold(4'b0111, SEG_4, 1'b1, 30);
    chk("en_on_same_dwell", {31'h0, busy}, 32'h0);
    chk("en_data", DATA_OUT, 32'h0);
    hold(4'hF, 7'h7F, 1'b1, 20);

    expect_pulse(1'b0, 32'h00020E41);
    scan(SEG_1, SEG_2, SEG_3, SEG_4, 4'b0010, 1'b0, 4);
    chk("final_data", DATA_OUT, 32'h00020E41);
    hold(4'hF, 7'h7F, 1'b1, 20);
    chk("queue_empty", expq.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
